mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port data RAM between three CPU-side requesters: 0 = instruction fetch, 1 = data/stack access (MOV/LEA/PUSH/POP), 2 = I/O or DMA.
- Arbitration is round-robin. Bus locking is optional, so a requester can hold the RAM across multi-word sequences such as XCH-to-memory or PUSH/POP bursts.
- Sits between the CPU FSM and the RAM macro. The RAM has a fixed 1-cycle read latency.

Parameters:
- N, 3, number of requesters (2..8).
- AW, 16, address width.
- DW, 16, data width.
- LOCK_MAX, 16, idle cycles a locked owner may hold the bus without requesting before the lock is forcibly released.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester access request; must be held until gnt.
- we  in  N  per-requester write enable, qualified by req.
- lock  in  N  per-requester: keep ownership after this access.
- addr  in  N*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  in  N*DW  packed write data, same packing as addr.
- gnt  out  N  one-hot; access accepted this cycle.
- rvalid  out  N  one-hot; read data valid for requester i.
- rdata  out  DW  read data, shared by all requesters.
- lock_err  out  1  one-cycle pulse when a lock is released by timeout.
- mem_en  out  1  RAM command strobe.
- mem_we  out  1  RAM write.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after a read command.

Behaviour:
- Reset values: ptr=0, locked=0, owner=0, idle_cnt=0, gnt=0, rvalid=0, rdata=0, lock_err=0, mem_en=0, mem_we=0.
- Arbitration is combinational in the same cycle. The winner is the first requester with req=1, searching from ptr upward modulo N.
- If locked=1, only the owner is eligible. Requests from all others are ignored and get no gnt.
- On a grant to requester w:
  - gnt[w]=1, mem_en=1, mem_we=we[w], mem_addr=addr[w], mem_wdata=wdata[w], all in that same cycle.
  - Registered update: ptr <= (w+1) mod N.
- Lock update on the granted access:
  - lock[w]=1: locked <= 1, owner <= w, idle_cnt <= 0.
  - lock[w]=0: locked <= 0.
- No requester eligible: gnt=0 and mem_en=0. mem_addr and mem_wdata are don't-care while mem_en=0.
- Read response: a granted read (we=0) produces rvalid[w]=1 and rdata=mem_rdata exactly 1 cycle after gnt.
  - A 1-entry tag pipeline carries w and a read flag.
  - Writes produce no rvalid.
  - Throughput is one access per cycle. Back-to-back reads from different requesters return in grant order.
- Lock timeout:
  - While locked and req[owner]=0, idle_cnt increments each cycle.
  - When idle_cnt reaches LOCK_MAX-1 and req[owner] is still 0: locked <= 0, lock_err pulses for 1 cycle, idle_cnt <= 0.
  - Any grant to the owner clears idle_cnt.
- Simultaneous events:
  - If the owner requests with lock=0 in the same cycle the timeout would fire, the grant wins and lock_err stays 0.
  - A timeout and a new requester in the same cycle: the new requester is not eligible until the next cycle.
- ptr wrap: after a grant to N-1, ptr becomes 0.
- Reset mid-operation: a read in flight on the reset cycle returns no rvalid; lock and ptr are cleared.
- Requester-side protocol violations: changing addr/we/wdata while waiting for gnt is allowed. The value sampled is the one present in the grant cycle.
- Structure: one registered state block (ptr, locked, owner, idle_cnt, response tag, rdata) plus a combinational arbiter. No further FSM states are needed beyond UNLOCKED and LOCKED, encoded by the locked bit.

Decomposition:
- Shared package cpu_pkg holds the requester index constants REQ_FETCH=0, REQ_DATA=1, REQ_IO=2 and the default AW/DW widths.
- One natural sub-module: rr_pick. It is a purely combinational function (req vector, ptr, enable mask) -> one-hot grant plus encoded winner index, reusable by a future interrupt controller.

Test Plan:
- Single read: after reset, req=3'b010, we=0, addr[1]=16'h0040, RAM holds 16'hBEEF at that address -> gnt=3'b010 the same cycle with mem_addr=16'h0040; next cycle rvalid=3'b010 and rdata=16'hBEEF.
- Round-robin fairness: all three req held high for 6 cycles, all reads -> grants 0,1,2,0,1,2; rvalid follows one cycle later in the same order.
- Write passthrough: req[2]=1, we[2]=1, addr=16'h0010, wdata=16'h1234 -> mem_en=1, mem_we=1, mem_wdata=16'h1234; no rvalid; a later read of 16'h0010 returns 16'h1234.
- Lock hold: requester 1 is granted with lock=1 while req[0] is high, then requester 1 issues 3 more accesses with lock=1 and a final access with lock=0 -> requester 0 gets no gnt during those 5 grants to requester 1, then is granted on the next cycle.
- Lock timeout: LOCK_MAX=4, requester 1 locks then drops req while req[0]=1 -> lock_err pulses on the 4th idle cycle and gnt[0]=1 on the following cycle.
- Reset mid-read: rst=1 on the cycle after a read grant -> rvalid stays 0, all outputs return to reset values, and ptr=0 is verified by the next grant with all requesters active going to requester 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU-side memory path: requester indices, default
// address/data widths and the lock state encoding used by mem_arbiter.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Requester slots on the data RAM arbiter.
  localparam int REQ_FETCH = 0;  // instruction fetch
  localparam int REQ_DATA  = 1;  // MOV/LEA/PUSH/POP data and stack traffic
  localparam int REQ_IO    = 2;  // I/O or DMA

  localparam int DEF_N        = 3;
  localparam int DEF_AW       = 16;
  localparam int DEF_DW       = 16;
  localparam int DEF_LOCK_MAX = 16;

  // The arbiter has exactly two modes; the enum value is the locked bit itself.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage : cpu_pkg

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Scans requesters starting at ptr_i
// and wrapping modulo N; the first one with both req_i and en_i set wins.
//
// Ports:
//   req_i    N   request vector
//   en_i     N   eligibility mask (a cleared bit hides that requester)
//   ptr_i    IW  highest-priority index for this cycle
//   gnt_o    N   one-hot grant (all zero when nobody wins)
//   idx_o    IW  encoded winner index (0 when nobody wins)
//   valid_o  1   a winner exists
// -----------------------------------------------------------------------------
module rr_pick
  import cpu_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  en_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every output gets a default before the loop; a path that leaves a
    // combinational output unassigned would infer a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand] && en_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing the single-port data RAM between N requesters,
// with optional bus locking and a lock watchdog. Grants and the RAM command
// are combinational in the request cycle; read data returns one cycle later.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req/we/lock [N]       per-requester request, write enable, keep-ownership
//   addr [N*AW]           packed addresses, requester i at [i*AW +: AW]
//   wdata [N*DW]          packed write data, same packing
//   gnt [N]               one-hot access accepted this cycle
//   rvalid [N]            one-hot read data valid
//   rdata [DW]            shared read data (holds the last value between reads)
//   lock_err              one-cycle pulse when a lock is released by timeout
//   mem_en/mem_we         RAM command strobe and write
//   mem_addr/mem_wdata    RAM address and write data
//   mem_rdata             RAM read data, valid the cycle after a read command
// -----------------------------------------------------------------------------
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N-1:0]    lock,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rvalid,
  output logic [DW-1:0]   rdata,
  output logic            lock_err,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int            IW        = $clog2(N);
  localparam int            CW        = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(LOCK_MAX - 1);
  localparam logic [IW-1:0] PTR_LAST  = IW'(N - 1);

  logic [IW-1:0] ptr_q, ptr_d;
  lock_state_e   state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          tag_valid_q, tag_valid_d;  // read in flight
  logic [IW-1:0] tag_idx_q, tag_idx_d;      // who issued it
  logic [DW-1:0] rdata_q;

  logic [N-1:0]  elig;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic          timeout;
  logic          resp_live;

  // While locked only the owner may win. Eligibility is taken from the
  // registered lock state, so a requester freed by a timeout competes from
  // the following cycle. Nothing is granted while reset is applied.
  always_comb begin
    if (rst)                    elig = '0;
    else if (state_q == LOCKED) elig = N'(1) << owner_q;
    else                        elig = '1;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .en_i    (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign mem_en    = win_valid;
  assign mem_we    = win_valid & we[win_idx];
  assign mem_addr  = addr[int'(win_idx)*AW +: AW];
  assign mem_wdata = wdata[int'(win_idx)*DW +: DW];

  // An owner request in the same cycle is granted instead, so it never times out.
  assign timeout  = !rst && (state_q == LOCKED) && !req[owner_q] && (idle_q == IDLE_LAST);
  assign lock_err = timeout;

  // Read data is passed straight from the RAM in its valid cycle and held
  // afterwards; a response due in a reset cycle is dropped.
  assign resp_live = tag_valid_q && !rst;
  assign rvalid    = resp_live ? (N'(1) << tag_idx_q) : '0;
  assign rdata     = resp_live ? mem_rdata : rdata_q;

  always_comb begin
    ptr_d       = ptr_q;
    state_d     = state_q;
    owner_d     = owner_q;
    idle_d      = idle_q;
    tag_valid_d = win_valid && !we[win_idx];
    tag_idx_d   = win_idx;

    if (win_valid) begin
      ptr_d  = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
      idle_d = '0;
      if (lock[win_idx]) begin
        state_d = LOCKED;
        owner_d = win_idx;
      end else begin
        state_d = UNLOCKED;
      end
    end else if ((state_q == LOCKED) && !req[owner_q]) begin
      if (timeout) begin
        state_d = UNLOCKED;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      state_q     <= UNLOCKED;
      owner_q     <= '0;
      idle_q      <= '0;
      tag_valid_q <= 1'b0;
      tag_idx_q   <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      idle_q      <= idle_d;
      tag_valid_q <= tag_valid_d;
      tag_idx_q   <= tag_idx_d;
      rdata_q     <= rdata;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small behavioural RAM (1-cycle read
// latency). Inputs change 1 ns after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import cpu_pkg::*;

  localparam int N        = 3;
  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int LOCK_MAX = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            lock_err;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   ram [0:255];

  int vectors     = 0;
  int miscompares = 0;

  mem_arbiter #(
    .N        (N),
    .AW       (AW),
    .DW       (DW),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .lock_err  (lock_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: ram[a] = 16'hA000 + a except where written or preloaded.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = r;
    we[i]             = w;
    lock[i]           = l;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req  = '0;
    we   = '0;
    lock = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt: observed %b expected 000", gnt); end
    vectors++; if (rvalid !== 3'b000) begin miscompares++; $display("FAIL reset_rvalid: observed %b expected 000", rvalid); end
    vectors++; if (rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata: observed %h expected 0000", rdata); end
    vectors++; if (lock_err !== 1'b0) begin miscompares++; $display("FAIL reset_lock_err: observed %b expected 0", lock_err); end
    vectors++; if ({mem_en, mem_we} !== 2'b00) begin miscompares++; $display("FAIL reset_mem_en_we: observed %b expected 00", {mem_en, mem_we}); end
    tick();
  endtask

  task automatic test_single_read();
    drive(REQ_DATA, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL single_gnt: observed %b expected 010", gnt); end
    vectors++; if ({mem_en, mem_we} !== 2'b10) begin miscompares++; $display("FAIL single_mem_en_we: observed %b expected 10", {mem_en, mem_we}); end
    vectors++; if (mem_addr !== 16'h0040) begin miscompares++; $display("FAIL single_mem_addr: observed %h expected 0040", mem_addr); end
    tick();
    idle_all();
    @(negedge clk);
    vectors++; if (rvalid !== 3'b010) begin miscompares++; $display("FAIL single_rvalid: observed %b expected 010", rvalid); end
    vectors++; if (rdata !== 16'hBEEF) begin miscompares++; $display("FAIL single_rdata: observed %h expected BEEF", rdata); end
    vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL single_gnt_after: observed %b expected 000", gnt); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_g;
    logic [DW-1:0] exp_d;
    do_reset();
    drive(REQ_FETCH, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    drive(REQ_DATA,  1'b1, 1'b0, 1'b0, 16'h0021, 16'h0000);
    drive(REQ_IO,    1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_g = N'(1) << (k % 3);
      vectors++; if (gnt !== exp_g) begin miscompares++; $display("FAIL rr_gnt[%0d]: observed %b expected %b", k, gnt, exp_g); end
      if (k > 0) begin
        exp_g = N'(1) << ((k - 1) % 3);
        exp_d = 16'hA020 + DW'((k - 1) % 3);
        vectors++; if (rvalid !== exp_g) begin miscompares++; $display("FAIL rr_rvalid[%0d]: observed %b expected %b", k, rvalid, exp_g); end
        vectors++; if (rdata !== exp_d) begin miscompares++; $display("FAIL rr_rdata[%0d]: observed %h expected %h", k, rdata, exp_d); end
      end
      tick();
    end
    idle_all();
    @(negedge clk);
    vectors++; if (rvalid !== 3'b100) begin miscompares++; $display("FAIL rr_rvalid_last: observed %b expected 100", rvalid); end
    vectors++; if (rdata !== 16'hA022) begin miscompares++; $display("FAIL rr_rdata_last: observed %h expected A022", rdata); end
    tick();
  endtask

  // Pointer is 0 here (last round-robin grant went to requester 2).
  task automatic test_write();
    drive(REQ_IO, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234);
    @(negedge clk);
    vectors++; if (gnt !== 3'b100) begin miscompares++; $display("FAIL wr_gnt: observed %b expected 100", gnt); end
    vectors++; if ({mem_en, mem_we} !== 2'b11) begin miscompares++; $display("FAIL wr_mem_en_we: observed %b expected 11", {mem_en, mem_we}); end
    vectors++; if (mem_addr !== 16'h0010) begin miscompares++; $display("FAIL wr_mem_addr: observed %h expected 0010", mem_addr); end
    vectors++; if (mem_wdata !== 16'h1234) begin miscompares++; $display("FAIL wr_mem_wdata: observed %h expected 1234", mem_wdata); end
    tick();
    idle_all();
    @(negedge clk);
    vectors++; if (rvalid !== 3'b000) begin miscompares++; $display("FAIL wr_no_rvalid: observed %b expected 000", rvalid); end
    tick();
    drive(REQ_FETCH, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL wr_readback_gnt: observed %b expected 001", gnt); end
    tick();
    idle_all();
    @(negedge clk);
    vectors++; if (rvalid !== 3'b001) begin miscompares++; $display("FAIL wr_readback_rvalid: observed %b expected 001", rvalid); end
    vectors++; if (rdata !== 16'h1234) begin miscompares++; $display("FAIL wr_readback_rdata: observed %h expected 1234", rdata); end
    tick();
  endtask

  // Pointer is 1 here; requester 1 wins first and then holds the bus.
  task automatic test_lock_hold();
    drive(REQ_FETCH, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
    drive(REQ_DATA,  1'b1, 1'b0, 1'b1, 16'h0031, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) addr[0 +: AW] = 16'h0033;  // waiting requester changes its address
      if (k == 4) lock[REQ_DATA] = 1'b0;
      @(negedge clk);
      vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL lock_hold_gnt[%0d]: observed %b expected 010", k, gnt); end
      tick();
    end
    req[REQ_DATA] = 1'b0;
    @(negedge clk);
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL lock_release_gnt: observed %b expected 001", gnt); end
    vectors++; if (mem_addr !== 16'h0033) begin miscompares++; $display("FAIL lock_release_addr: observed %h expected 0033", mem_addr); end
    vectors++; if (rvalid !== 3'b010) begin miscompares++; $display("FAIL lock_last_rvalid: observed %b expected 010", rvalid); end
    vectors++; if (rdata !== 16'hA031) begin miscompares++; $display("FAIL lock_last_rdata: observed %h expected A031", rdata); end
    tick();
    idle_all();
    tick();
  endtask

  // Pointer is 1 on entry to both lock-timeout tests.
  task automatic test_lock_timeout();
    logic exp_err;
    drive(REQ_FETCH, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
    drive(REQ_DATA,  1'b1, 1'b0, 1'b1, 16'h0031, 16'h0000);
    @(negedge clk);
    vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL to_lock_gnt: observed %b expected 010", gnt); end
    tick();
    req[REQ_DATA]  = 1'b0;
    lock[REQ_DATA] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_err = (k == 4);
      @(negedge clk);
      vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL to_idle_gnt[%0d]: observed %b expected 000", k, gnt); end
      vectors++; if (lock_err !== exp_err) begin miscompares++; $display("FAIL to_lock_err[%0d]: observed %b expected %b", k, lock_err, exp_err); end
      tick();
    end
    @(negedge clk);
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL to_freed_gnt: observed %b expected 001", gnt); end
    vectors++; if (lock_err !== 1'b0) begin miscompares++; $display("FAIL to_lock_err_after: observed %b expected 0", lock_err); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_grant_beats_timeout();
    drive(REQ_FETCH, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
    drive(REQ_DATA,  1'b1, 1'b0, 1'b1, 16'h0031, 16'h0000);
    @(negedge clk);
    vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL race_lock_gnt: observed %b expected 010", gnt); end
    tick();
    req[REQ_DATA]  = 1'b0;
    lock[REQ_DATA] = 1'b0;
    tick();
    tick();
    tick();
    req[REQ_DATA] = 1'b1;  // owner returns exactly on the timeout cycle
    @(negedge clk);
    vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL race_owner_gnt: observed %b expected 010", gnt); end
    vectors++; if (lock_err !== 1'b0) begin miscompares++; $display("FAIL race_lock_err: observed %b expected 0", lock_err); end
    tick();
    req[REQ_DATA] = 1'b0;
    @(negedge clk);
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL race_next_gnt: observed %b expected 001", gnt); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(REQ_DATA, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h0000);
    @(negedge clk);
    vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL rstmid_gnt: observed %b expected 010", gnt); end
    tick();
    rst = 1'b1;
    drive(REQ_FETCH, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    drive(REQ_IO,    1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000);
    @(negedge clk);
    vectors++; if (rvalid !== 3'b000) begin miscompares++; $display("FAIL rstmid_rvalid: observed %b expected 000", rvalid); end
    vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL rstmid_gnt_in_rst: observed %b expected 000", gnt); end
    vectors++; if ({mem_en, lock_err} !== 2'b00) begin miscompares++; $display("FAIL rstmid_en_err: observed %b expected 00", {mem_en, lock_err}); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL rstmid_ptr0_gnt: observed %b expected 001", gnt); end
    vectors++; if (rvalid !== 3'b000) begin miscompares++; $display("FAIL rstmid_rvalid_after: observed %b expected 000", rvalid); end
    vectors++; if (rdata !== 16'h0000) begin miscompares++; $display("FAIL rstmid_rdata: observed %h expected 0000", rdata); end
    tick();
    idle_all();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + DW'(i);
    ram[8'h40] = 16'hBEEF;
    mem_rdata  = '0;
    rst   = 1'b1;
    req   = '0;
    we    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;

    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_lock_hold();
    test_lock_timeout();
    test_grant_beats_timeout();
    test_reset_mid_read();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_arbiter
